// File: rtl/key_debouncer_pkg.sv
// Shared organ definitions: key count, key vector type and small bit-vector
// helpers used by the front-end, setting and playback stages.
package organ_pkg;

  localparam int unsigned NUM_KEYS = 8;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  localparam key_vec_t KEY_NONE = key_vec_t'(1'b0);
  localparam key_vec_t KEY_ONE  = key_vec_t'(1'b1);

  // Keep only the lowest set bit of a key vector (zero stays zero).
  function automatic key_vec_t isolate_lowest(input key_vec_t v);
    return v & (~v + KEY_ONE);
  endfunction

  // True when two or more bits of the key vector are set.
  function automatic logic more_than_one(input key_vec_t v);
    return ((v & (v - KEY_ONE)) != KEY_NONE);
  endfunction

endpackage : organ_pkg

// File: rtl/key_debouncer_cell.sv
// One debounce channel: two-flop synchroniser, hold counter and accepted
// level. A new level is accepted once the synchronised input has differed
// from the accepted level for DEBOUNCE_CYCLES consecutive cycles; a single
// agreeing cycle restarts the count.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic slow_clk,
  input  logic rst_n,
  input  logic raw,
  output logic stb,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_r;
  logic             s2_r;
  logic             stb_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             stb_nxt_s;
  logic             accept_s;

  // Bring the asynchronous switch into the slow_clk domain.
  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= raw;
      s2_r <= s1_r;
    end
  end

  // Hold counter: clear on agreement, accept at the last count, else advance.
  always_comb begin
    cnt_nxt_s = cnt_r;
    stb_nxt_s = stb_r;
    accept_s  = 1'b0;
    if (s2_r == stb_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      accept_s  = 1'b1;
      stb_nxt_s = s2_r;
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Counter and accepted-level registers.
  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
      stb_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      stb_r <= stb_nxt_s;
    end
  end

  assign stb = stb_r;
  // Accept strobe for a 0->1 transition. It is registered by the consumer
  // on the same edge that loads stb, so the registered pulse lines up with
  // the first cycle in which stb reads 1.
  assign rise = accept_s & s2_r;

endmodule : debounce_cell

// File: rtl/key_debouncer.sv
// Organ front end: debounces the eight note keys and the escape key and
// emits registered single-cycle press pulses. The key pulse word is always
// zero or one-hot; simultaneous accepted presses keep only the lowest key
// and raise multi_press for that cycle.
module key_debouncer
  import organ_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic       slow_clk,
  input  logic       rst_n,
  input  logic [7:0] raw_buts,
  input  logic       raw_esc,
  output logic [7:0] stable_buts,
  output logic       stable_esc,
  output logic [7:0] pose_buts,
  output logic       pose_esc,
  output logic       multi_press
);

  key_vec_t key_stb_s;
  key_vec_t key_rise_s;
  logic     esc_stb_s;
  logic     esc_rise_s;

  key_vec_t pose_buts_nxt_s;
  logic     multi_nxt_s;

  key_vec_t pose_buts_r;
  logic     pose_esc_r;
  logic     multi_r;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .slow_clk (slow_clk),
      .rst_n    (rst_n),
      .raw      (raw_buts[i]),
      .stb      (key_stb_s[i]),
      .rise     (key_rise_s[i])
    );
  end

  debounce_cell #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_esc_cell (
    .slow_clk (slow_clk),
    .rst_n    (rst_n),
    .raw      (raw_esc),
    .stb      (esc_stb_s),
    .rise     (esc_rise_s)
  );

  // Arbitrate simultaneous key rises: lowest index wins, the rest are dropped.
  always_comb begin
    pose_buts_nxt_s = KEY_NONE;
    multi_nxt_s     = 1'b0;
    if (key_rise_s != KEY_NONE) begin
      pose_buts_nxt_s = isolate_lowest(key_rise_s);
      multi_nxt_s     = more_than_one(key_rise_s);
    end else begin
      pose_buts_nxt_s = KEY_NONE;
      multi_nxt_s     = 1'b0;
    end
  end

  // Pulse output registers, all loaded on the same edge as the stable levels.
  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      pose_buts_r <= KEY_NONE;
      pose_esc_r  <= 1'b0;
      multi_r     <= 1'b0;
    end else begin
      pose_buts_r <= pose_buts_nxt_s;
      pose_esc_r  <= esc_rise_s;
      multi_r     <= multi_nxt_s;
    end
  end

  assign stable_buts = key_stb_s;
  assign stable_esc  = esc_stb_s;
  assign pose_buts   = pose_buts_r;
  assign pose_esc    = pose_esc_r;
  assign multi_press = multi_r;

endmodule : key_debouncer
